tlb_walk_arbiter: RTL and testbench

- Shares the single page-table walker (MMU) between the Itlb and the Dtlb.
- Accepts miss requests from both TLBs and grants them round-robin, with one walk outstanding at a time.
- Routes each walker response back to the TLB that issued the request.
- Handles TLB flush and walker timeout, so a hung or stale walk never corrupts a TLB or deadlocks the memory system.

---
 rtl/tlb_walk_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_tlb_walk_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_walk_arbiter.sv
// Round-robin arbiter that shares one page-table walker between the Itlb and Dtlb.
// One walk in flight; handles flush (stale walks) and walker timeout.
module tlb_walk_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int PERM_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  itlb_req_valid,
    input  logic [ADDR_WIDTH-1:0] itlb_req_addr,
    output logic                  itlb_resp_valid,
    output logic [ADDR_WIDTH-1:0] itlb_resp_addr,
    output logic [PERM_WIDTH-1:0] itlb_resp_perm_bits,
    output logic                  itlb_resp_fault,
    input  logic                  dtlb_req_valid,
    input  logic [ADDR_WIDTH-1:0] dtlb_req_addr,
    output logic                  dtlb_resp_valid,
    output logic [ADDR_WIDTH-1:0] dtlb_resp_addr,
    output logic [PERM_WIDTH-1:0] dtlb_resp_perm_bits,
    output logic                  dtlb_resp_fault,
    output logic                  mmu_req_valid,
    input  logic                  mmu_req_ready,
    output logic [ADDR_WIDTH-1:0] mmu_req_addr,
    input  logic                  mmu_resp_valid,
    input  logic [ADDR_WIDTH-1:0] mmu_resp_addr,
    input  logic [PERM_WIDTH-1:0] mmu_resp_perm_bits,
    input  logic                  mmu_resp_fault,
    input  logic                  flush,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_grant_q, last_grant_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  stale_q, stale_d;
    logic                  drain_after_q, drain_after_d;
    logic                  mmu_req_valid_q, mmu_req_valid_d;
    logic [ADDR_WIDTH-1:0] mmu_req_addr_q, mmu_req_addr_d;
    logic                  busy_q, busy_d;

    logic                  rsp_valid_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_d;
    logic [PERM_WIDTH-1:0] rsp_perm_d;
    logic                  rsp_fault_d;

    logic                  itlb_resp_valid_q, itlb_resp_valid_d;
    logic [ADDR_WIDTH-1:0] itlb_resp_addr_q, itlb_resp_addr_d;
    logic [PERM_WIDTH-1:0] itlb_resp_perm_q, itlb_resp_perm_d;
    logic                  itlb_resp_fault_q, itlb_resp_fault_d;
    logic                  dtlb_resp_valid_q, dtlb_resp_valid_d;
    logic [ADDR_WIDTH-1:0] dtlb_resp_addr_q, dtlb_resp_addr_d;
    logic [PERM_WIDTH-1:0] dtlb_resp_perm_q, dtlb_resp_perm_d;
    logic                  dtlb_resp_fault_q, dtlb_resp_fault_d;

    // Next-state logic: grant, walker handshake, response capture, flush and timeout.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        stale_d        = stale_q;
        drain_after_d  = drain_after_q;
        mmu_req_addr_d = mmu_req_addr_q;
        rsp_valid_d    = 1'b0;
        rsp_addr_d     = '0;
        rsp_perm_d     = '0;
        rsp_fault_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (itlb_req_valid || dtlb_req_valid) begin
                    if (itlb_req_valid && dtlb_req_valid) begin
                        owner_d = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
                    end else if (dtlb_req_valid) begin
                        owner_d = OWN_D;
                    end else begin
                        owner_d = OWN_I;
                    end
                    last_grant_d   = owner_d;
                    mmu_req_addr_d = (owner_d == OWN_D) ? dtlb_req_addr
                                                        : itlb_req_addr;
                    stale_d        = 1'b0;
                    drain_after_d  = 1'b0;
                    state_d        = S_REQ;
                end
            end
            S_REQ: begin
                // A flushed request is still issued; its answer is drained.
                if (flush) begin
                    stale_d = 1'b1;
                end
                if (mmu_req_ready) begin
                    cnt_d          = '0;
                    stale_d        = 1'b0;
                    mmu_req_addr_d = '0;
                    state_d        = (stale_q || flush) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (flush) begin
                    state_d = mmu_resp_valid ? S_IDLE : S_DRAIN;
                end else if (mmu_resp_valid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = mmu_resp_addr;
                    rsp_perm_d  = mmu_resp_perm_bits;
                    rsp_fault_d = mmu_resp_fault;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_fault_d   = 1'b1;
                    drain_after_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = drain_after_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (mmu_resp_valid) begin
                    drain_after_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mmu_req_valid_d   = (state_d == S_REQ);
        busy_d            = (state_d != S_IDLE);

        itlb_resp_valid_d = rsp_valid_d && (owner_q == OWN_I);
        itlb_resp_addr_d  = (owner_q == OWN_I) ? rsp_addr_d : '0;
        itlb_resp_perm_d  = (owner_q == OWN_I) ? rsp_perm_d : '0;
        itlb_resp_fault_d = rsp_fault_d && (owner_q == OWN_I);
        dtlb_resp_valid_d = rsp_valid_d && (owner_q == OWN_D);
        dtlb_resp_addr_d  = (owner_q == OWN_D) ? rsp_addr_d : '0;
        dtlb_resp_perm_d  = (owner_q == OWN_D) ? rsp_perm_d : '0;
        dtlb_resp_fault_d = rsp_fault_d && (owner_q == OWN_D);
    end

    // State and registered outputs; reset clears everything and favours the Dtlb.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            owner_q           <= OWN_I;
            last_grant_q      <= OWN_I;
            cnt_q             <= '0;
            stale_q           <= 1'b0;
            drain_after_q     <= 1'b0;
            mmu_req_valid_q   <= 1'b0;
            mmu_req_addr_q    <= '0;
            busy_q            <= 1'b0;
            itlb_resp_valid_q <= 1'b0;
            itlb_resp_addr_q  <= '0;
            itlb_resp_perm_q  <= '0;
            itlb_resp_fault_q <= 1'b0;
            dtlb_resp_valid_q <= 1'b0;
            dtlb_resp_addr_q  <= '0;
            dtlb_resp_perm_q  <= '0;
            dtlb_resp_fault_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            owner_q           <= owner_d;
            last_grant_q      <= last_grant_d;
            cnt_q             <= cnt_d;
            stale_q           <= stale_d;
            drain_after_q     <= drain_after_d;
            mmu_req_valid_q   <= mmu_req_valid_d;
            mmu_req_addr_q    <= mmu_req_addr_d;
            busy_q            <= busy_d;
            itlb_resp_valid_q <= itlb_resp_valid_d;
            itlb_resp_addr_q  <= itlb_resp_addr_d;
            itlb_resp_perm_q  <= itlb_resp_perm_d;
            itlb_resp_fault_q <= itlb_resp_fault_d;
            dtlb_resp_valid_q <= dtlb_resp_valid_d;
            dtlb_resp_addr_q  <= dtlb_resp_addr_d;
            dtlb_resp_perm_q  <= dtlb_resp_perm_d;
            dtlb_resp_fault_q <= dtlb_resp_fault_d;
        end
    end

    assign mmu_req_valid       = mmu_req_valid_q;
    assign mmu_req_addr        = mmu_req_addr_q;
    assign busy                = busy_q;
    assign itlb_resp_valid     = itlb_resp_valid_q;
    assign itlb_resp_addr      = itlb_resp_addr_q;
    assign itlb_resp_perm_bits = itlb_resp_perm_q;
    assign itlb_resp_fault     = itlb_resp_fault_q;
    assign dtlb_resp_valid     = dtlb_resp_valid_q;
    assign dtlb_resp_addr      = dtlb_resp_addr_q;
    assign dtlb_resp_perm_bits = dtlb_resp_perm_q;
    assign dtlb_resp_fault     = dtlb_resp_fault_q;

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Scoreboard bench for tlb_walk_arbiter: directed walks, arbitration,
// back-pressure, flush, timeout and mid-walk reset.
module tb_tlb_walk_arbiter;

    localparam int AW = 64;
    localparam int PW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          itlb_req_valid = 1'b0;
    logic [AW-1:0] itlb_req_addr = '0;
    logic          itlb_resp_valid;
    logic [AW-1:0] itlb_resp_addr;
    logic [PW-1:0] itlb_resp_perm_bits;
    logic          itlb_resp_fault;
    logic          dtlb_req_valid = 1'b0;
    logic [AW-1:0] dtlb_req_addr = '0;
    logic          dtlb_resp_valid;
    logic [AW-1:0] dtlb_resp_addr;
    logic [PW-1:0] dtlb_resp_perm_bits;
    logic          dtlb_resp_fault;
    logic          mmu_req_valid;
    logic          mmu_req_ready = 1'b1;
    logic [AW-1:0] mmu_req_addr;
    logic          mmu_resp_valid = 1'b0;
    logic [AW-1:0] mmu_resp_addr = '0;
    logic [PW-1:0] mmu_resp_perm_bits = '0;
    logic          mmu_resp_fault = 1'b0;
    logic          flush = 1'b0;
    logic          busy;

    tlb_walk_arbiter #(
        .ADDR_WIDTH    (AW),
        .PERM_WIDTH    (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .itlb_req_valid     (itlb_req_valid),
        .itlb_req_addr      (itlb_req_addr),
        .itlb_resp_valid    (itlb_resp_valid),
        .itlb_resp_addr     (itlb_resp_addr),
        .itlb_resp_perm_bits(itlb_resp_perm_bits),
        .itlb_resp_fault    (itlb_resp_fault),
        .dtlb_req_valid     (dtlb_req_valid),
        .dtlb_req_addr      (dtlb_req_addr),
        .dtlb_resp_valid    (dtlb_resp_valid),
        .dtlb_resp_addr     (dtlb_resp_addr),
        .dtlb_resp_perm_bits(dtlb_resp_perm_bits),
        .dtlb_resp_fault    (dtlb_resp_fault),
        .mmu_req_valid      (mmu_req_valid),
        .mmu_req_ready      (mmu_req_ready),
        .mmu_req_addr       (mmu_req_addr),
        .mmu_resp_valid     (mmu_resp_valid),
        .mmu_resp_addr      (mmu_resp_addr),
        .mmu_resp_perm_bits (mmu_resp_perm_bits),
        .mmu_resp_fault     (mmu_resp_fault),
        .flush              (flush),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          tlb;
        logic [AW-1:0] addr;
        logic [PW-1:0] perm;
        logic          fault;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] mmu_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void push_exp(logic t, logic [AW-1:0] a,
                                     logic [PW-1:0] p, logic f);
        exp_t e;
        e.tlb   = t;
        e.addr  = a;
        e.perm  = p;
        e.fault = f;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares every TLB response and every walker handshake.
    always @(negedge clk) begin
        if (reset && (itlb_resp_valid || dtlb_resp_valid)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp itlb=%0b dtlb=%0b required=none",
                         itlb_resp_valid, dtlb_resp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_both", 64'(itlb_resp_valid & dtlb_resp_valid), 64'(0));
                chk("resp_owner", 64'(dtlb_resp_valid), 64'(mon_e.tlb));
                if (dtlb_resp_valid) begin
                    chk("dtlb_addr", dtlb_resp_addr, mon_e.addr);
                    chk("dtlb_perm", 64'(dtlb_resp_perm_bits), 64'(mon_e.perm));
                    chk("dtlb_fault", 64'(dtlb_resp_fault), 64'(mon_e.fault));
                    chk("itlb_idle_addr", itlb_resp_addr, 64'(0));
                    chk("itlb_idle_flt", 64'(itlb_resp_fault), 64'(0));
                end else begin
                    chk("itlb_addr", itlb_resp_addr, mon_e.addr);
                    chk("itlb_perm", 64'(itlb_resp_perm_bits), 64'(mon_e.perm));
                    chk("itlb_fault", 64'(itlb_resp_fault), 64'(mon_e.fault));
                    chk("dtlb_idle_addr", dtlb_resp_addr, 64'(0));
                    chk("dtlb_idle_flt", 64'(dtlb_resp_fault), 64'(0));
                end
            end
        end
        if (reset && mmu_req_valid && mmu_req_ready) begin
            if (mmu_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mmu_req actual=%0h required=none",
                         mmu_req_addr);
            end else begin
                chk("mmu_req_addr", mmu_req_addr, mmu_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mmu_req();
        int n = 0;
        while (!mmu_req_valid && n < 50) begin
            tick();
            n++;
        end
        chk("mmu_req_seen", 64'(mmu_req_valid), 64'(1));
    endtask

    task automatic pulse_resp(logic [AW-1:0] a, logic [PW-1:0] p, logic f);
        mmu_resp_valid     = 1'b1;
        mmu_resp_addr      = a;
        mmu_resp_perm_bits = p;
        mmu_resp_fault     = f;
        tick();
        mmu_resp_valid     = 1'b0;
        mmu_resp_addr      = '0;
        mmu_resp_perm_bits = '0;
        mmu_resp_fault     = 1'b0;
    endtask

    task automatic wait_tlb_resp();
        int n = 0;
        while (!itlb_resp_valid && !dtlb_resp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("tlb_resp_seen", 64'(itlb_resp_valid | dtlb_resp_valid), 64'(1));
        if (itlb_resp_valid) itlb_req_valid = 1'b0;
        if (dtlb_resp_valid) dtlb_req_valid = 1'b0;
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_mreq"}, 64'(mmu_req_valid), 64'(0));
        chk({tag, "_maddr"}, mmu_req_addr, 64'(0));
        chk({tag, "_iv"}, 64'(itlb_resp_valid), 64'(0));
        chk({tag, "_dv"}, 64'(dtlb_resp_valid), 64'(0));
        chk({tag, "_ia"}, itlb_resp_addr, 64'(0));
        chk({tag, "_da"}, dtlb_resp_addr, 64'(0));
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        itlb_req_valid = 1'b0;
        dtlb_req_valid = 1'b0;
        flush          = 1'b0;
        mmu_req_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #1;
        chk_quiet("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single Itlb miss
        itlb_req_addr = 64'h4000_1000;
        mmu_q.push_back(64'h4000_1000);
        push_exp(1'b0, 64'h8000_5000, 8'hCF, 1'b0);
        itlb_req_valid = 1'b1;
        chk("t1_req_early", 64'(mmu_req_valid), 64'(0));
        tick();
        chk("t1_req_lat", 64'(mmu_req_valid), 64'(1));
        tick();
        tick();
        tick();
        pulse_resp(64'h8000_5000, 8'hCF, 1'b0);
        wait_tlb_resp();
        tick();
        chk("t1_idle", 64'(busy), 64'(0));

        // Simultaneous requests out of reset: Dtlb first
        do_reset();
        itlb_req_addr = 64'h1111_2000;
        dtlb_req_addr = 64'h2222_3000;
        mmu_q.push_back(64'h2222_3000);
        mmu_q.push_back(64'h1111_2000);
        push_exp(1'b1, 64'h8000_A000, 8'h0F, 1'b0);
        push_exp(1'b0, 64'h8000_B000, 8'hC3, 1'b0);
        itlb_req_valid = 1'b1;
        dtlb_req_valid = 1'b1;
        wait_mmu_req();
        tick();
        pulse_resp(64'h8000_A000, 8'h0F, 1'b0);
        wait_tlb_resp();
        wait_mmu_req();
        tick();
        pulse_resp(64'h8000_B000, 8'hC3, 1'b0);
        wait_tlb_resp();
        tick();

        // Walker back-pressure for 5 cycles
        mmu_req_ready = 1'b0;
        itlb_req_addr = 64'h7777_0000;
        mmu_q.push_back(64'h7777_0000);
        push_exp(1'b0, 64'h9000_0000, 8'h07, 1'b1);
        itlb_req_valid = 1'b1;
        wait_mmu_req();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_v", 64'(mmu_req_valid), 64'(1));
            chk("t3_hold_a", mmu_req_addr, 64'h7777_0000);
            tick();
        end
        mmu_req_ready = 1'b1;
        chk("t3_v6", 64'(mmu_req_valid), 64'(1));
        tick();
        chk("t3_hs_done", 64'(mmu_req_valid), 64'(0));
        pulse_resp(64'h9000_0000, 8'h07, 1'b1);
        wait_tlb_resp();
        tick();

        // Flush during WAIT discards the walk
        dtlb_req_addr = 64'h3333_4000;
        mmu_q.push_back(64'h3333_4000);
        dtlb_req_valid = 1'b1;
        wait_mmu_req();
        tick();
        flush = 1'b1;
        dtlb_req_valid = 1'b0;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_busy", 64'(busy), 64'(1));
            tick();
        end
        pulse_resp(64'hDEAD_0000, 8'hFF, 1'b0);
        chk("t4_idle", 64'(busy), 64'(0));
        tick();
        chk("t4_still_idle", 64'(busy), 64'(0));

        // Timeout after TO cycles in WAIT, then drain
        dtlb_req_addr = 64'h5555_6000;
        mmu_q.push_back(64'h5555_6000);
        push_exp(1'b1, 64'h0, 8'h00, 1'b1);
        dtlb_req_valid = 1'b1;
        wait_mmu_req();
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("t5_no_resp", 64'(dtlb_resp_valid), 64'(0));
            tick();
        end
        chk("t5_timeout", 64'(dtlb_resp_valid), 64'(1));
        dtlb_req_valid = 1'b0;
        tick();
        chk("t5_drain", 64'(busy), 64'(1));
        tick();
        tick();
        chk("t5_drain2", 64'(busy), 64'(1));
        pulse_resp(64'hBEEF_0000, 8'hAA, 1'b0);
        chk("t5_idle", 64'(busy), 64'(0));

        // Reset in WAIT, stale response ignored, then a normal walk
        itlb_req_addr = 64'h6666_7000;
        mmu_q.push_back(64'h6666_7000);
        itlb_req_valid = 1'b1;
        wait_mmu_req();
        tick();
        tick();
        reset = 1'b0;
        itlb_req_valid = 1'b0;
        #1;
        chk_quiet("t6_rst");
        tick();
        reset = 1'b1;
        tick();
        pulse_resp(64'hCAFE_0000, 8'h11, 1'b0);
        chk("t6_ignored", 64'(busy), 64'(0));
        itlb_req_addr = 64'h6666_8000;
        mmu_q.push_back(64'h6666_8000);
        push_exp(1'b0, 64'h8888_9000, 8'h5B, 1'b0);
        itlb_req_valid = 1'b1;
        wait_mmu_req();
        tick();
        pulse_resp(64'h8888_9000, 8'h5B, 1'b0);
        wait_tlb_resp();
        tick();

        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        chk("mmu_q_empty", 64'(mmu_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
